// File: rtl/cordic_fp_pkg.sv
// cordic_fp_pkg: shared widths, Q2.19 word type and IEEE-754 single field layout for the CORDIC float/fixed stages
package cordic_fp_pkg;
   localparam int FIXED_W = 21;
   localparam int FRAC_W = 19;
   localparam int FP_EXP_BIAS = 127;
   localparam int FP_MANT_W = 23;
   typedef logic signed [FIXED_W-1:0] q2_19_t;
   typedef struct packed {
      logic sign;
      logic [7:0] exp;
      logic [FP_MANT_W-1:0] mant;
   } fp32_t;
endpackage

// File: rtl/lzc21.sv
// lzc21: combinational leading-one detector; din -> idx (position of highest set bit), nz (din != 0)
module lzc21 (
   input logic [20:0] din,
   output logic [4:0] idx,
   output logic nz
);
   always_comb begin
      idx = '0;
      for (int i = 0; i < 21; i++) idx = din[i] ? 5'(i) : idx;
   end
   assign nz = |din;
endmodule

// File: rtl/cordic_fixed_to_float.sv
// cordic_fixed_to_float: 3-stage Q2.19 -> IEEE-754 single converter; clock/aclr/clk_en control, in_valid+fixed_in in, result_valid+result out
module cordic_fixed_to_float
   import cordic_fp_pkg::*;
#(
   parameter int FIXED_W = cordic_fp_pkg::FIXED_W,
   parameter int FRAC_W = cordic_fp_pkg::FRAC_W
) (
   input logic clock,
   input logic aclr,
   input logic clk_en,
   input logic in_valid,
   input logic [FIXED_W-1:0] fixed_in,
   output logic result_valid,
   output logic [31:0] result
);
   logic s1_s_q, s1_s_d, s1_v_q, s1_v_d;
   logic [FIXED_W-1:0] s1_mag_q, s1_mag_d;
   logic s2_s_q, s2_s_d, s2_v_q, s2_v_d, s2_z_q, s2_z_d;
   logic [FIXED_W-1:0] s2_mag_q, s2_mag_d;
   logic [4:0] s2_p_q, s2_p_d;
   logic [31:0] result_q, result_d;
   logic result_valid_q, result_valid_d;
   logic [4:0] lz_idx;
   logic lz_nz;
   fp32_t packed_fp;
   lzc21 u_lzc (.din(s1_mag_q), .idx(lz_idx), .nz(lz_nz));
   always_comb begin
      s1_s_d = fixed_in[FIXED_W-1];
      s1_mag_d = s1_s_d ? FIXED_W'(-fixed_in) : fixed_in;
      s1_v_d = in_valid;
      s2_s_d = s1_s_q;
      s2_mag_d = s1_mag_q;
      s2_v_d = s1_v_q;
      s2_p_d = lz_idx;
      s2_z_d = ~lz_nz;
      packed_fp.sign = s2_s_q & ~s2_z_q;
      packed_fp.exp = s2_z_q ? 8'd0 : 8'(s2_p_q) + 8'(FP_EXP_BIAS - FRAC_W);
      packed_fp.mant = s2_z_q ? '0 : FP_MANT_W'((FP_MANT_W + 1)'(s2_mag_q) << (5'(FP_MANT_W) - s2_p_q));
      result_d = s2_v_q ? packed_fp : result_q;
      result_valid_d = s2_v_q;
   end
   always_ff @(posedge clock) begin
      if (aclr) begin
         s1_s_q <= 1'b0;
         s1_mag_q <= '0;
         s1_v_q <= 1'b0;
         s2_s_q <= 1'b0;
         s2_mag_q <= '0;
         s2_v_q <= 1'b0;
         s2_p_q <= '0;
         s2_z_q <= 1'b1;
         result_q <= '0;
         result_valid_q <= 1'b0;
      end else if (clk_en) begin
         s1_s_q <= s1_s_d;
         s1_mag_q <= s1_mag_d;
         s1_v_q <= s1_v_d;
         s2_s_q <= s2_s_d;
         s2_mag_q <= s2_mag_d;
         s2_v_q <= s2_v_d;
         s2_p_q <= s2_p_d;
         s2_z_q <= s2_z_d;
         result_q <= result_d;
         result_valid_q <= result_valid_d;
      end
   end
   assign result = result_q;
   assign result_valid = result_valid_q;
endmodule

// File: tb/tb_cordic_fixed_to_float.sv
// tb_cordic_fixed_to_float: randomized and directed bench against a real-arithmetic reference model
module tb_cordic_fixed_to_float;
   logic clock = 1'b0;
   logic aclr = 1'b1;
   logic clk_en = 1'b0;
   logic in_valid = 1'b0;
   logic [20:0] fixed_in = '0;
   logic result_valid;
   logic [31:0] result;
   int checks = 0;
   int failures = 0;
   logic [21:0] hist[$];
   logic exp_v = 1'b0;
   logic [31:0] exp_r = '0;
   always #5 clock = ~clock;
   cordic_fixed_to_float dut (
      .clock(clock), .aclr(aclr), .clk_en(clk_en), .in_valid(in_valid),
      .fixed_in(fixed_in), .result_valid(result_valid), .result(result)
   );
   function automatic logic [31:0] conv(input logic [20:0] f);
      real r;
      logic [63:0] b;
      r = real'($signed(f)) / 524288.0;
      if (r == 0.0) return 32'h0;
      b = $realtobits(r);
      return {b[63], 8'(int'(b[62:52]) - 896), b[51:29]};
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
      end
   endtask
   task automatic tick(input logic a, input logic en, input logic v, input logic [20:0] d);
      logic [21:0] e;
      aclr = a;
      clk_en = en;
      in_valid = v;
      fixed_in = d;
      @(posedge clock);
      if (a) begin
         hist.delete();
         exp_v = 1'b0;
         exp_r = '0;
      end else if (en) begin
         hist.push_back({v, d});
         if (hist.size() == 3) begin
            e = hist.pop_front();
            exp_v = e[21];
            if (e[21]) exp_r = conv(e[20:0]);
         end
      end
      @(negedge clock);
      check("result_valid", 32'(result_valid), 32'(exp_v));
      check("result", result, exp_r);
   endtask
   initial begin
      logic [20:0] pin_in[8] = '{21'h080000, 21'h040000, 21'h180000, 21'h000000,
                                 21'h000001, 21'h0FFFFF, 21'h100000, 21'h1FFFFF};
      logic [31:0] pin_out[8] = '{32'h3F800000, 32'h3F000000, 32'hBF800000, 32'h00000000,
                                  32'h36000000, 32'h3FFFFFF0, 32'hC0000000, 32'hB6000000};
      logic [20:0] cosv[11];
      @(negedge clock);
      tick(1, 0, 0, 0);
      tick(1, 1, 1, 21'h080000);
      check("reset_valid", 32'(result_valid), 32'd0);
      check("reset_result", result, 32'd0);
      for (int i = 0; i < 8; i++) check("model_pin", conv(pin_in[i]), pin_out[i]);
      for (int i = 0; i < 8; i++) tick(0, 1, 1, pin_in[i]);
      for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
      for (int i = 0; i < 11; i++) cosv[i] = 21'(int'($cos(i * 0.1) * 524288.0));
      for (int i = 0; i < 11; i++) tick(0, 1, 1, cosv[i]);
      for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
      for (int i = 0; i < 6; i++) tick(0, 1, 1, cosv[i]);
      for (int i = 0; i < 4; i++) tick(0, 0, 1, 21'h1ABCDE);
      for (int i = 6; i < 11; i++) tick(0, 1, 1, cosv[i]);
      for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
      tick(0, 1, 1, 21'h0C0000);
      tick(0, 1, 1, 21'h140000);
      tick(1, 1, 1, 21'h0A0000);
      check("flush_valid", 32'(result_valid), 32'd0);
      check("flush_result", result, 32'd0);
      tick(0, 1, 1, 21'h040000);
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      check("post_reset", result, 32'h3F000000);
      for (int i = 0; i < 12; i++) tick(0, 1, i[0] == 1'b0, 21'($urandom));
      for (int i = 0; i < 3000; i++) begin
         logic [20:0] d;
         d = 21'($urandom);
         case ($urandom_range(0, 7))
            0: d = 21'h100000;
            1: d = 21'h0;
            2: d = 21'($urandom_range(0, 3));
            default: ;
         endcase
         tick($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, d);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
